// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame sequencer: state encoding, default frame
// geometry and a minimal OBI request/response pair.
package cnn_pkg;

  localparam int unsigned DefaultImgWidth  = 28;
  localparam int unsigned DefaultImgHeight = 28;
  localparam int unsigned DefaultOutCount  = 169;
  localparam int unsigned BYTES_PER_WORD   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StStream,
    StWrReq,
    StWrWait,
    StFinish
  } cnn_seq_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        user;
  } cnn_obi_a_t;

  typedef struct packed {
    logic       req;
    cnn_obi_a_t a;
  } cnn_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } cnn_obi_r_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    cnn_obi_r_t r;
  } cnn_obi_rsp_t;

  // Byte enables for the lowest `lanes` byte lanes.
  function automatic logic [3:0] lanes_to_be(input logic [2:0] lanes);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < lanes) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/cnn_seq_packer.sv
// Four-lane byte packer: result bytes fill lanes 0..3 in order; the partially filled word
// exposes byte enables for exactly the filled lanes, unused lanes read as zero.
module cnn_seq_packer
  import cnn_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic [3:0]  be_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [2:0]      count_q, count_d;
  logic [3:0][7:0] data_q, data_d;

  always_comb begin
    count_d = count_q;
    data_d  = data_q;
    if (clear_i) begin
      count_d = '0;
      data_d  = '0;
    end else if (push_i && !full_o) begin
      data_d[count_q[1:0]] = data_i;
      count_d              = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign full_o  = (count_q == 3'(BYTES_PER_WORD));
  assign empty_o = (count_q == '0);
  assign word_o  = data_q;
  assign be_o    = lanes_to_be(count_q);

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer: streams an input image from memory as pixels and writes packed pooled results
// back over one shared OBI manager port. Define CNN_SEQ_PERF_EN to build the busy-cycle counter.
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned ImgWidth  = DefaultImgWidth,
  parameter int unsigned ImgHeight = DefaultImgHeight,
  parameter int unsigned OutCount  = DefaultOutCount,
  parameter type         obi_req_t = cnn_obi_req_t,
  parameter type         obi_rsp_t = cnn_obi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] input_base_i,
  input  logic [31:0] output_base_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] perf_cycles_o,
  output obi_req_t    mgr_obi_req_o,
  input  obi_rsp_t    mgr_obi_rsp_i,
  output logic [7:0]  pix_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  input  logic [7:0]  res_i,
  input  logic        res_valid_i,
  output logic        res_ready_o
);

  localparam int unsigned PixTotal = ImgWidth * ImgHeight;
  localparam int unsigned OutWords = (OutCount + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
  localparam int unsigned PixW     = $clog2(PixTotal + 1);
  localparam int unsigned WrW      = $clog2(OutWords + 1);
  localparam int unsigned ResW     = $clog2(OutCount + 1);

  localparam logic [PixW-1:0] PixLast = PixW'(PixTotal - 1);
  localparam logic [PixW-1:0] PixAll  = PixW'(PixTotal);
  localparam logic [WrW-1:0]  WrLast  = WrW'(OutWords - 1);
  localparam logic [WrW-1:0]  WrAll   = WrW'(OutWords);
  localparam logic [ResW-1:0] ResAll  = ResW'(OutCount);

  cnn_seq_state_e  state_q, state_d;
  logic [31:0]     in_base_q, in_base_d, out_base_q, out_base_d;
  logic [31:0]     word_q, word_d;
  logic [PixW-1:0] pix_cnt_q, pix_cnt_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [WrW-1:0]  wr_word_q, wr_word_d;
  logic [ResW-1:0] res_cnt_q, res_cnt_d;
  logic            err_q, err_d;

  logic        accept_start, rsp_ok, rsp_err, pix_hs, last_pix, word_end, wr_pending;
  logic        pk_clear, pk_push, pk_full, pk_empty;
  logic [31:0] pk_word;
  logic [3:0]  pk_be;

  assign accept_start = (state_q == StIdle) && start_i;
  assign rsp_ok       = mgr_obi_rsp_i.rvalid && !mgr_obi_rsp_i.r.err;
  assign rsp_err      = mgr_obi_rsp_i.rvalid && mgr_obi_rsp_i.r.err &&
                        ((state_q == StRdWait) || (state_q == StWrWait));
  assign pix_hs       = (state_q == StStream) && pix_ready_i;
  assign last_pix     = (pix_cnt_q == PixLast);
  assign word_end     = pix_hs && ((byte_idx_q == 2'd3) || last_pix);
  // A full word, or the trailing partial word once every result has arrived.
  assign wr_pending   = pk_full || ((res_cnt_q == ResAll) && !pk_empty);
  assign pk_clear     = accept_start || ((state_q == StWrWait) && rsp_ok);
  assign pk_push      = res_valid_i && res_ready_o;

  cnn_seq_packer u_packer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (pk_clear),
    .push_i  (pk_push),
    .data_i  (res_i),
    .word_o  (pk_word),
    .be_o    (pk_be),
    .full_o  (pk_full),
    .empty_o (pk_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StRdReq;
      StRdReq:  if (mgr_obi_rsp_i.gnt) state_d = StRdWait;
      StRdWait: if (mgr_obi_rsp_i.rvalid) state_d = mgr_obi_rsp_i.r.err ? StFinish : StStream;
      StStream: begin
        if (word_end) begin
          if (wr_pending)              state_d = StWrReq;
          else if (!last_pix)          state_d = StRdReq;
          else if (wr_word_q != WrAll) state_d = StWrReq;
          else                         state_d = StFinish;
        end
      end
      // Without a pending word this state just waits for the pipeline to drain results.
      StWrReq:  if (wr_pending && mgr_obi_rsp_i.gnt) state_d = StWrWait;
      StWrWait: begin
        if (mgr_obi_rsp_i.rvalid) begin
          if (mgr_obi_rsp_i.r.err || (wr_word_q == WrLast)) state_d = StFinish;
          else if (pix_cnt_q != PixAll)                      state_d = StRdReq;
          else                                               state_d = StWrReq;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    word_d     = word_q;
    pix_cnt_d  = pix_cnt_q;
    byte_idx_d = byte_idx_q;
    wr_word_d  = wr_word_q;
    res_cnt_d  = res_cnt_q;
    err_d      = err_q;
    if (accept_start) begin
      in_base_d  = input_base_i;
      out_base_d = output_base_i;
      pix_cnt_d  = '0;
      byte_idx_d = '0;
      wr_word_d  = '0;
      res_cnt_d  = '0;
      err_d      = 1'b0;
    end
    if ((state_q == StRdWait) && rsp_ok) begin
      word_d     = mgr_obi_rsp_i.r.rdata;
      byte_idx_d = '0;
    end
    if (pix_hs) begin
      pix_cnt_d  = pix_cnt_q + PixW'(1);
      byte_idx_d = byte_idx_q + 2'd1;
    end
    if (pk_push) res_cnt_d = res_cnt_q + ResW'(1);
    if ((state_q == StWrWait) && rsp_ok) wr_word_d = wr_word_q + WrW'(1);
    if (rsp_err) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_base_q  <= '0;
      out_base_q <= '0;
      word_q     <= '0;
      pix_cnt_q  <= '0;
      byte_idx_q <= '0;
      wr_word_q  <= '0;
      res_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      word_q     <= word_d;
      pix_cnt_q  <= pix_cnt_d;
      byte_idx_q <= byte_idx_d;
      wr_word_q  <= wr_word_d;
      res_cnt_q  <= res_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    mgr_obi_req_o = '0;
    busy_o        = (state_q != StIdle) && (state_q != StFinish);
    done_o        = (state_q == StFinish);
    pix_valid_o   = (state_q == StStream);
    res_ready_o   = busy_o && !wr_pending && (res_cnt_q != ResAll) && (state_q != StWrWait);
    if (state_q == StRdReq) begin
      // Pixels are bytes, so the pixel count at a word boundary is the byte offset.
      mgr_obi_req_o.req    = 1'b1;
      mgr_obi_req_o.a.addr = in_base_q + 32'(pix_cnt_q);
      mgr_obi_req_o.a.be   = 4'hF;
    end else if ((state_q == StWrReq) && wr_pending) begin
      mgr_obi_req_o.req     = 1'b1;
      mgr_obi_req_o.a.we    = 1'b1;
      mgr_obi_req_o.a.addr  = out_base_q + (32'(wr_word_q) << 2);
      mgr_obi_req_o.a.be    = pk_be;
      mgr_obi_req_o.a.wdata = pk_word;
    end
  end

  assign pix_o = word_q[{byte_idx_q, 3'b000} +: 8];
  assign err_o = err_q;

`ifdef CNN_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      perf_q <= '0;
    else if (accept_start)            perf_q <= '0;
    else if (busy_o && perf_q != '1)  perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: expected bus, pixel and write traffic is queued per
// frame and a negedge monitor pops and compares whenever the DUT presents a transfer.
module tb_cnn_frame_sequencer;
  import cnn_pkg::*;

  localparam int NPix = 784;
  localparam int NRes = 169;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } wr_exp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [31:0]  input_base_i = '0;
  logic [31:0]  output_base_i = '0;
  logic         busy_o, done_o, err_o;
  logic [31:0]  perf_cycles_o;
  cnn_obi_req_t mgr_obi_req_o;
  cnn_obi_rsp_t mgr_obi_rsp_i;
  logic [7:0]   pix_o;
  logic         pix_valid_o;
  logic         pix_ready_i;
  logic [7:0]   res_i;
  logic         res_valid_i;
  logic         res_ready_o;

  cnn_frame_sequencer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .input_base_i  (input_base_i),
    .output_base_i (output_base_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .perf_cycles_o (perf_cycles_o),
    .mgr_obi_req_o (mgr_obi_req_o),
    .mgr_obi_rsp_i (mgr_obi_rsp_i),
    .pix_o         (pix_o),
    .pix_valid_o   (pix_valid_o),
    .pix_ready_i   (pix_ready_i),
    .res_i         (res_i),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd[$];
  wr_exp_t     exp_wr[$];
  logic [7:0]  exp_pix[$];
  int          gnt_delay = 0;
  int          err_at_read = 0;
  bit          toggle_ready = 1'b0;
  int          mem_rd = 0;
  int          mem_wr = 0;
  int          pix_acc = 0;
  int          res_idx = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F96;
  endfunction

  function automatic logic [7:0] res_val(input int k);
    return 8'(k * 7 + 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory and datapath stand-in, driven #1 after each rising edge.
  initial begin : drive
    int          wait_cnt;
    bit          pend, pend_err;
    logic [31:0] pend_data;
    wait_cnt = 0;
    pend = 1'b0;
    pend_err = 1'b0;
    pend_data = '0;
    mgr_obi_rsp_i = '0;
    pix_ready_i = 1'b1;
    res_valid_i = 1'b0;
    res_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mgr_obi_rsp_i = '0;
      if (!rst_ni) begin
        pend = 1'b0;
        wait_cnt = 0;
      end else begin
        if (pend) begin
          mgr_obi_rsp_i.rvalid  = 1'b1;
          mgr_obi_rsp_i.r.rdata = pend_data;
          mgr_obi_rsp_i.r.err   = pend_err;
          pend = 1'b0;
        end
        if (mgr_obi_req_o.req) begin
          if (wait_cnt >= gnt_delay) begin
            mgr_obi_rsp_i.gnt = 1'b1;
            wait_cnt = 0;
            pend = 1'b1;
            pend_err = 1'b0;
            pend_data = '0;
            if (!mgr_obi_req_o.a.we) begin
              mem_rd++;
              pend_data = mem_word(mgr_obi_req_o.a.addr);
              pend_err = (err_at_read != 0) && (mem_rd == err_at_read);
            end else begin
              mem_wr++;
            end
          end else begin
            wait_cnt++;
          end
        end
      end
      pix_ready_i = toggle_ready ? !pix_ready_i : 1'b1;
      res_valid_i = rst_ni && (res_idx < NRes) && ((pix_acc >= 4 * res_idx + 120) || (pix_acc == NPix));
      res_i = res_val(res_idx);
    end
  end

  initial begin : monitor
    bit           hold_v;
    cnn_obi_req_t held;
    wr_exp_t      e;
    hold_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        hold_v = 1'b0;
      end else begin
        if (busy_o) busy_cnt++;
        if (done_o) done_cnt++;
        if (mgr_obi_req_o.req) begin
          if (hold_v) chk("req_held", 32'(mgr_obi_req_o != held), 32'd0);
          if (mgr_obi_rsp_i.gnt) begin
            hold_v = 1'b0;
            if (!mgr_obi_req_o.a.we) begin
              chk("rd_while_pix_valid", 32'(pix_valid_o), 32'd0);
              chk("rd_be", 32'(mgr_obi_req_o.a.be), 32'hF);
              if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got read 0x%08h, expected none",
                         mgr_obi_req_o.a.addr);
              end else begin
                chk("rd_addr", mgr_obi_req_o.a.addr, exp_rd.pop_front());
              end
            end else if (exp_wr.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL wr_unexpected: got write 0x%08h, expected none",
                       mgr_obi_req_o.a.addr);
            end else begin
              e = exp_wr.pop_front();
              chk("wr_addr", mgr_obi_req_o.a.addr, e.addr);
              chk("wr_be", 32'(mgr_obi_req_o.a.be), 32'(e.be));
              chk("wr_data", mgr_obi_req_o.a.wdata, e.wdata);
            end
          end else begin
            hold_v = 1'b1;
            held = mgr_obi_req_o;
          end
        end
        if (pix_valid_o && pix_ready_i) begin
          if (exp_pix.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pix_unexpected: got pixel 0x%02h, expected none", pix_o);
          end else begin
            chk("pix", 32'(pix_o), 32'(exp_pix.pop_front()));
          end
          pix_acc++;
        end
        if (res_valid_i && res_ready_o) res_idx++;
      end
    end
  end

  task automatic push_frame(input logic [31:0] ib, input logic [31:0] ob, input int n_rd,
                            input int n_pix, input int n_wr);
    exp_rd.delete();
    exp_wr.delete();
    exp_pix.delete();
    for (int w = 0; w < n_rd; w++) begin
      logic [31:0] d;
      d = mem_word(ib + 32'(4 * w));
      exp_rd.push_back(ib + 32'(4 * w));
      for (int l = 0; l < 4; l++) begin
        if (4 * w + l < n_pix) exp_pix.push_back(d[8*l +: 8]);
      end
    end
    for (int j = 0; j < n_wr; j++) begin
      wr_exp_t e;
      e.addr = ob + 32'(4 * j);
      e.be = '0;
      e.wdata = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * j + l < NRes) begin
          e.wdata[8*l +: 8] = res_val(4 * j + l);
          e.be[l] = 1'b1;
        end
      end
      exp_wr.push_back(e);
    end
  endtask

  task automatic start_frame(input logic [31:0] ib, input logic [31:0] ob);
    pix_acc = 0;
    res_idx = 0;
    done_cnt = 0;
    busy_cnt = 0;
    mem_rd = 0;
    mem_wr = 0;
    @(posedge clk_i);
    #1;
    input_base_i = ib;
    output_base_i = ob;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("start_req", 32'(mgr_obi_req_o.req), 32'd1);
    chk("start_addr", mgr_obi_req_o.a.addr, ib);
    chk("start_busy", 32'(busy_o), 32'd1);
    chk("start_err_clr", 32'(err_o), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_o in %0d cycles, expected done_o", budget);
    end
  endtask

  task automatic end_checks(input int rd, input int wr, input bit err);
    repeat (4) @(negedge clk_i);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_after", 32'(busy_o), 32'd0);
    chk("err_after", 32'(err_o), 32'(err));
    chk("read_count", 32'(mem_rd), 32'(rd));
    chk("write_count", 32'(mem_wr), 32'(wr));
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    chk("pix_left", 32'(exp_pix.size()), 32'd0);
  endtask

  task automatic chk_perf();
`ifdef CNN_SEQ_PERF_EN
    chk("perf_cycles", perf_cycles_o, 32'(busy_cnt));
`else
    chk("perf_cycles", perf_cycles_o, 32'd0);
`endif
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid_o), 32'd0);
    chk("rst_res_ready", 32'(res_ready_o), 32'd0);
    chk("rst_req", 32'(mgr_obi_req_o.req), 32'd0);
    chk("rst_perf", perf_cycles_o, 32'd0);
  endtask

  initial begin : main
    int n;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs();
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Plain frame, always-ready memory and datapath.
    push_frame(32'h1000, 32'h2000, 196, NPix, 43);
    start_frame(32'h1000, 32'h2000);
    wait_done(10000);
    end_checks(196, 43, 1'b0);
    chk_perf();

    // Throttled pixels, slow grant, and an ignored start while busy.
    toggle_ready = 1'b1;
    gnt_delay = 3;
    push_frame(32'h4000, 32'h8000, 196, NPix, 43);
    start_frame(32'h4000, 32'h8000);
    repeat (200) @(posedge clk_i);
    #1;
    input_base_i = 32'hDEAD_0000;
    output_base_i = 32'hBEEF_0000;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_done(20000);
    end_checks(196, 43, 1'b0);

    // Bus error on the tenth read aborts the frame.
    toggle_ready = 1'b0;
    gnt_delay = 0;
    err_at_read = 10;
    push_frame(32'h1000, 32'h2000, 10, 36, 0);
    start_frame(32'h1000, 32'h2000);
    n = 0;
    while (!(mgr_obi_rsp_i.rvalid && mgr_obi_rsp_i.r.err) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (!(mgr_obi_rsp_i.rvalid && mgr_obi_rsp_i.r.err)) begin
      checks++;
      errors++;
      $display("FAIL err_rvalid_timeout: got no erroring rvalid, expected one");
    end else begin
      @(negedge clk_i);
      chk("err_done_next", 32'(done_o), 32'd1);
      chk("err_sticky", 32'(err_o), 32'd1);
    end
    end_checks(10, 0, 1'b1);
    err_at_read = 0;

    // Restart clears the error; then reset mid-frame.
    push_frame(32'h1000, 32'h2000, 196, NPix, 43);
    start_frame(32'h1000, 32'h2000);
    repeat (100) @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs();
    exp_rd.delete();
    exp_wr.delete();
    exp_pix.delete();
    @(negedge clk_i);
    chk_reset_outputs();
    rst_ni = 1'b1;
    mem_rd = 0;
    mem_wr = 0;
    repeat (20) @(negedge clk_i);
    chk("post_rst_reads", 32'(mem_rd), 32'd0);
    chk("post_rst_writes", 32'(mem_wr), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    // Recovery frame after reset.
    toggle_ready = 1'b1;
    gnt_delay = 1;
    push_frame(32'h3000, 32'h5000, 196, NPix, 43);
    start_frame(32'h3000, 32'h5000);
    wait_done(20000);
    end_checks(196, 43, 1'b0);
    chk_perf();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
